// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch stage: PC, next-PC select, req/ack IM fetch, IR and field decode
module ifetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWr,
  input  logic                 IRWr,
  input  logic [1:0]           NPCOp,
  input  logic [31:0]          rs_data,
  output logic                 im_req,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_rdata,
  input  logic                 im_ack,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          instr,
  output logic [5:0]           op,
  output logic [5:0]           funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [15:0]          imm16,
  output logic                 ir_valid,
  output logic                 fetch_busy,
  output logic                 pc_misalign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   im_req_q, im_req_d;
  logic [IM_ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic                   pc_misalign_q, pc_misalign_d;

  logic [31:0]            pc_inc;
  logic [31:0]            br_off;
  logic [31:0]            npc;

  // Branch offsets are relative to the already-incremented PC held in pc_q.
  always_comb begin
    pc_inc = pc_q + 32'd4;
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc    = pc_inc;
    unique case (NPCOp)
      NPC_PLUS4:  npc = pc_inc;
      NPC_BRANCH: npc = pc_q + br_off;
      NPC_JUMP:   npc = {pc_q[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     npc = {rs_data[31:2], 2'b00};
      default:    npc = pc_inc;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    ir_valid_d    = ir_valid_q;
    im_req_d      = im_req_q;
    im_addr_d     = im_addr_q;
    pc_misalign_d = pc_misalign_q;

    if (PCWr) begin
      pc_d = npc;
      if (NPCOp == NPC_JR && rs_data[1:0] != 2'b00) begin
        pc_misalign_d = 1'b1;
      end
    end

    // Fetch address is taken from pc_q, so a same-cycle PCWr does not affect it.
    unique case (state_q)
      S_IDLE: begin
        if (IRWr) begin
          im_addr_d = pc_q[IM_ADDR_W+1:2];
          im_req_d  = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (im_ack) begin
          instr_d    = im_rdata;
          ir_valid_d = 1'b1;
          im_req_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        im_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      instr_q       <= 32'd0;
      ir_valid_q    <= 1'b0;
      im_req_q      <= 1'b0;
      im_addr_q     <= '0;
      pc_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      ir_valid_q    <= ir_valid_d;
      im_req_q      <= im_req_d;
      im_addr_q     <= im_addr_d;
      pc_misalign_q <= pc_misalign_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign funct       = instr_q[5:0];
  assign imm16       = instr_q[15:0];
  assign ir_valid    = ir_valid_q;
  assign im_req      = im_req_q;
  assign im_addr     = im_addr_q;
  assign fetch_busy  = (state_q != S_IDLE);
  assign pc_misalign = pc_misalign_q;

endmodule
